ubus_sdram_responder: RTL
=========================

// Module: ubus_sdram_responder
// PURPOSE
//  Responder (memory) end of the unidirectional request/response bus; the initiator drives the request channel, this block answers.
//  Accepts one read/write request at a time, models SDRAM timing (activate tRCD, CAS latency) on an internal word array,
//  returns read data on a separate response channel with valid/ready handshake. Sits behind the bus as the SDRAM target.
// PARAMETERS
//  DATA_WIDTH   16  data word width (bits)
//  ADDR_WIDTH   8   word address width; array depth = 2**ADDR_WIDTH
//  T_RCD        2   activate-to-column cycles; legal >= 1
//  CAS_LATENCY  3   read column-to-data cycles; legal >= 1
//  PATH_DELAY   3   simulation-only #delay on all register updates (ns); 0 legal; no functional effect
// PORTS
//  clk          in   1           rising-edge clock
//  reset        in   1           asynchronous, active-low reset
//  req_valid    in   1           request present
//  req_ready    out  1           responder can accept request
//  req_we       in   1           1 = write, 0 = read
//  req_addr     in   ADDR_WIDTH  word address
//  req_wdata    in   DATA_WIDTH  write data
//  rsp_valid    out  1           read data valid
//  rsp_ready    in   1           initiator accepts read data
//  rsp_rdata    out  DATA_WIDTH  read data
//  busy         out  1           request in flight (state != IDLE)
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0, counter=0. Array contents NOT reset.
//  First posedge after reset release: req_ready->1. All outputs registered.
//  FSM: IDLE -> ACTIVATE -> (WRITE | CAS -> RESP) -> IDLE.
//   IDLE: req_ready=1. Accept on posedge with req_valid&req_ready: latch we/addr/wdata, req_ready->0, busy->1,
//         counter=T_RCD-1, go ACTIVATE. req_* ignored when req_ready=0.
//   ACTIVATE: stay T_RCD cycles (counter to 0); then write->WRITE, read->CAS with counter=CAS_LATENCY-1.
//   WRITE: one cycle; array[addr]<=wdata at its closing edge; same edge req_ready->1, busy->0, go IDLE.
//   CAS: stay CAS_LATENCY cycles; at closing edge rsp_rdata<=array[addr], rsp_valid->1, go RESP.
//   RESP: hold rsp_valid=1, rsp_rdata stable while rsp_ready=0 (indefinitely).
//         Posedge with rsp_valid&rsp_ready: rsp_valid->0, req_ready->1, busy->0, go IDLE.
//  Latency (accept edge = edge 0): write committed at edge T_RCD+1, next accept earliest edge T_RCD+2;
//   rsp_valid high after edge T_RCD+CAS_LATENCY (defaults: write commit edge 3, rsp_valid after edge 5).
//  rsp_rdata keeps last read value after handshake until next read completes.
//  One outstanding request max; no pipelining, no reordering.
//  Read after write to same address returns new data (write committed before req_ready reasserts).
//  Counter width = clog2(max(T_RCD,CAS_LATENCY))+1; no wrap (loaded each phase).
//  Address wraps naturally within 2**ADDR_WIDTH; no out-of-range condition.
//  Reset mid-operation: FSM to IDLE immediately; uncommitted write discarded (array unchanged); pending read dropped,
//   rsp_valid->0; committed array contents retained.
// TESTING
//  1 Reset: hold reset=0 3 cycles -> req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0; release -> req_ready=1 next edge.
//  2 Write 0xA5A5 @0x10 then read 0x10, rsp_ready=1 -> write commit edge 3, rsp_valid after edge 5 of read, rsp_rdata=0xA5A5.
//  3 Read 0x10 with rsp_ready=0 for 10 cycles -> rsp_valid stays 1, rsp_rdata=0xA5A5 stable, req_ready=0; rsp_ready=1 -> IDLE next edge.
//  4 Write 0x1234 @0xFF, write 0x5678 @0x00, read both -> 0x1234, 0x5678 (address extremes, back-to-back accepts at T_RCD+2 spacing).
//  5 Assert reset during ACTIVATE of write 0xBEEF @0x10 -> array[0x10] still 0xA5A5 on subsequent read; mid-CAS reset -> no rsp_valid.
//  6 Params T_RCD=1, CAS_LATENCY=1 -> read rsp_valid after edge 2; req_valid held high in RESP never accepted extra request.

Source files
------------

// File: rtl/ubus_sdram_responder.sv
// Memory-side responder on the request/response bus: one request at a time, with SDRAM-like
// activate (tRCD) and CAS latency modelled in front of an internal word array.
module ubus_sdram_responder #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned T_RCD       = 2,
    parameter int unsigned CAS_LATENCY = 3,
    parameter int unsigned PATH_DELAY  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy
);
    localparam int unsigned CNT_MAX = (T_RCD > CAS_LATENCY) ? T_RCD : CAS_LATENCY;
    localparam int unsigned CW      = $clog2(CNT_MAX) + 1;
    localparam int unsigned DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [CW-1:0] RCD_LOAD = CW'(T_RCD - 1);
    localparam logic [CW-1:0] CAS_LOAD = CW'(CAS_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVATE,
        S_WRITE,
        S_CAS,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  busy_q, busy_d;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // PATH_DELAY only shaped simulation timing of the old model; it has no hardware meaning.
    if (PATH_DELAY != 0) begin : g_path_delay_sim_only
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        busy_d      = busy_q;
        mem_we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // req_ready comes up one edge after reset release, before any accept
                if (!req_ready_q) begin
                    req_ready_d = 1'b1;
                end else if (req_valid) begin
                    we_d        = req_we;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    cnt_d       = RCD_LOAD;
                    state_d     = S_ACTIVATE;
                end
            end
            S_ACTIVATE: begin
                if (cnt_q == '0) begin
                    if (we_q) begin
                        state_d = S_WRITE;
                    end else begin
                        cnt_d   = CAS_LOAD;
                        state_d = S_CAS;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WRITE: begin
                mem_we      = 1'b1;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
            S_CAS: begin
                if (cnt_q == '0) begin
                    rsp_rdata_d = mem_q[addr_q];
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
        end
    end

    // Array is not reset; a reset during WRITE forces state_q to IDLE so the write is dropped.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;

endmodule
